sdram_port_arbiter: RTL

//  Shares the single SDRAM-width memory port (25b addr, 32b data) between NUM_REQ requesters.

---
 rtl/sdram_port_arbiter_pkg.sv | 30 +++
 rtl/sdram_arb_id_fifo.sv | 71 +++++++
 rtl/sdram_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter slice.
//   mem_addr_t / mem_data_t : memory port address (25b) and data (32b)
//   mem_req_t               : one request slot {we, addr, wdata}
//   arb_state_e             : request slot state {IDLE, ISSUE}
//   id_width()              : bits needed to name one of n requesters
package sdram_port_arbiter_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] mem_addr_t;
  typedef logic [DATA_W-1:0] mem_data_t;

  typedef struct packed {
    logic      we;
    mem_addr_t addr;
    mem_data_t wdata;
  } mem_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // A single requester still needs a one-bit ID so vectors stay non-empty.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arb_id_fifo.sv
// Synchronous FIFO of requester IDs for reads in flight at the memory port.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (FIFO emptied)
//   push      : enqueue push_id (accepted when not full, or when a pop frees a slot)
//   push_id   : requester ID of the read being issued
//   pop       : dequeue the head (ignored while empty)
//   head_id   : ID at the head, valid while !empty
//   full      : DEPTH entries held
//   empty     : no entries held
module sdram_arb_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head_id,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] id_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);

  // The head is read combinationally: the response strobe is registered
  // from it in the very cycle the memory returns data.
  assign head_id = id_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      id_mem[wr_ptr_reg] <= push_id;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM-width memory port (25b addr, 32b data) between NUM_REQ
// requesters. Requester 0 is the scene loader (writes); the rest read.
// Round-robin grant into a registered request slot; read data returns in
// issue order and is steered back to the issuer via an ID FIFO.
//
// Build option: define SDRAM_ARB_LOADER_PRIO_EN to give requester 0 absolute
// priority whenever it is eligible (round-robin then runs over 1..NUM_REQ-1);
// without it, plain round-robin over all requesters.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   req_valid      : per-requester request valid
//   req_ready      : one-hot grant, request taken when valid & ready
//   req_we         : per-requester 1 = write, 0 = read
//   req_addr       : packed addresses, requester i at [25*i +: 25]
//   req_wdata      : packed write data, requester i at [32*i +: 32]
//   rsp_valid      : one-hot read-data strobe to the issuing requester
//   rsp_data       : read data shared by all requesters
//   mem_valid/ready, mem_we, mem_addr, mem_wdata : request to memory controller
//   mem_rsp_valid, mem_rsp_data : read return, strictly in issue order
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_OUTST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_W-1:0]         mem_rsp_data
);

  localparam int IDX_W = id_width(NUM_REQ);

`ifdef SDRAM_ARB_LOADER_PRIO_EN
  // Round-robin candidates exclude the loader, which is handled first.
  localparam logic [NUM_REQ-1:0] RR_MASK = {{(NUM_REQ-1){1'b1}}, 1'b0};
`endif

  arb_state_e         state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  mem_req_t           slot_reg, slot_next;
  logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
  mem_data_t          rsp_data_reg, rsp_data_next;

  mem_req_t           req_sel [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic               slot_free;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               grant_valid;
  logic [NUM_REQ-1:0] grant_oh;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_can_push;
  logic [IDX_W-1:0]   fifo_head;

  // First candidate at or after 'start', wrapping at NUM_REQ.
  // Returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                             input logic [IDX_W-1:0]   start);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(start) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
    return {found, idx};
  endfunction

  // A read may be issued if the FIFO has room now, or a response pops
  // an entry in this same cycle. Writes never touch the FIFO.
  assign fifo_pop      = mem_rsp_valid & ~fifo_empty;
  assign fifo_can_push = ~fifo_full | fifo_pop;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_sel[gi] = {req_we[gi],
                          req_addr[ADDR_W*gi +: ADDR_W],
                          req_wdata[DATA_W*gi +: DATA_W]};
    assign elig[gi]    = req_valid[gi] & (req_we[gi] | fifo_can_push);
    assign rsp_valid_next[gi] = fifo_pop && (fifo_head == IDX_W'(gi));
  end

  assign rsp_data_next = fifo_pop ? mem_rsp_data : rsp_data_reg;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    slot_next  = slot_reg;
    grant_oh   = '0;
    fifo_push  = 1'b0;
    // The slot can take a new request if empty, or if its occupant
    // is being accepted by the controller this cycle.
    slot_free  = (state_reg == IDLE) || mem_ready;
`ifdef SDRAM_ARB_LOADER_PRIO_EN
    if (elig[0]) begin
      {pick_found, pick_idx} = {1'b1, IDX_W'(0)};
    end else begin
      {pick_found, pick_idx} = rr_pick(elig & RR_MASK, ptr_reg);
    end
`else
    {pick_found, pick_idx} = rr_pick(elig, ptr_reg);
`endif
    // No grant may escape while reset is held (reset is asynchronous).
    grant_valid = slot_free && pick_found && !rst;
    if (grant_valid) begin
      grant_oh[pick_idx] = 1'b1;
      slot_next          = req_sel[pick_idx];
      fifo_push          = !req_sel[pick_idx].we;
      state_next         = ISSUE;
      ptr_next           = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end else if (slot_free) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      slot_reg      <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      slot_reg      <= slot_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  sdram_arb_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .push_id (pick_idx),
    .pop     (fifo_pop),
    .head_id (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign req_ready = grant_oh;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign mem_valid = (state_reg == ISSUE);
  assign mem_we    = slot_reg.we;
  assign mem_addr  = slot_reg.addr;
  assign mem_wdata = slot_reg.wdata;

  // Read data with nothing in flight is a controller protocol error;
  // it is dropped above (no pop, no strobe) and flagged here.
  a_rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    !(mem_rsp_valid && fifo_empty));

endmodule
